// File: rtl/razor_pkg.sv
// Shared state codes and bit-vector helpers for the razor recovery controller.
package razor_pkg;

  localparam int RAZOR_NUM_STAGES = 5;
  localparam int RAZOR_MAX_W      = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RESTORE = 3'd1;
  localparam state_t ST_CLEAR   = 3'd2;
  localparam state_t ST_DRAIN   = 3'd3;
  localparam state_t ST_FAULT   = 3'd4;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [RAZOR_MAX_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = RAZOR_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Bits strictly above idx; the top stage index produces an empty mask.
  function automatic logic [RAZOR_MAX_W-1:0] flush_mask(input logic [4:0] idx);
    return ~((RAZOR_MAX_W'(2) << idx) - RAZOR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/razor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module razor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor error-recovery sequencer: stall, shadow restore, clear, drain, retry/fault.
// Optional per-stage error histogram enabled by RAZOR_STAGE_HIST_EN.
module razor_recovery_ctrl
  import razor_pkg::*;
#(
  parameter int NUM_STAGES   = RAZOR_NUM_STAGES,
  parameter int STALL_CYCLES = 1,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] err_in,
  output logic                  stall,
  output logic [NUM_STAGES-1:0] restore_sel,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  razor_clr,
  output logic                  busy,
  output logic                  fault,
  output logic [IDX_W-1:0]      err_stage,
  output logic [CNT_W-1:0]      err_count
`ifdef RAZOR_STAGE_HIST_EN
  ,
  output logic [NUM_STAGES*8-1:0] stage_hist
`endif
);

  localparam int DW_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam int RT_W = $clog2(MAX_RETRY + 1);
  localparam logic [DW_W-1:0] DWELL_INIT  = DW_W'(STALL_CYCLES - 1);
  localparam logic [RT_W-1:0] RETRY_LIMIT = RT_W'(MAX_RETRY);

  state_t                  state_reg, state_next;
  logic [NUM_STAGES-1:0]   cap_reg, cap_next;
  logic [IDX_W-1:0]        err_stage_reg, err_stage_next;
  logic [DW_W-1:0]         dwell_reg, dwell_next;
  logic [RT_W-1:0]         retry_reg, retry_next;
  logic                    stall_reg, busy_reg, clr_reg, fault_reg;
  logic [NUM_STAGES-1:0]   restore_sel_reg, flush_reg;
  logic [NUM_STAGES-1:0]   flush_next;
  logic [IDX_W-1:0]        low_idx;
  logic                    entry_inc;

  assign low_idx    = IDX_W'(lowest_set(RAZOR_MAX_W'(err_in)));
  assign flush_next = NUM_STAGES'(flush_mask(5'(err_stage_next)));
  assign entry_inc  = (state_reg == ST_IDLE) && (state_next == ST_RESTORE);

  always_comb begin
    state_next     = state_reg;
    cap_next       = cap_reg;
    err_stage_next = err_stage_reg;
    dwell_next     = dwell_reg;
    retry_next     = retry_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|err_in) begin
          state_next     = ST_RESTORE;
          cap_next       = err_in;
          err_stage_next = low_idx;
          retry_next     = '0;
          dwell_next     = DWELL_INIT;
        end
      end
      ST_RESTORE: begin
        // Late-arriving errors join the restore set; an earlier stage moves the flush point.
        cap_next = cap_reg | err_in;
        if ((|err_in) && (low_idx < err_stage_reg)) err_stage_next = low_idx;
        if (dwell_reg == '0) state_next = ST_CLEAR;
        else                 dwell_next = dwell_reg - 1'b1;
      end
      ST_CLEAR: begin
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (|err_in) begin
          retry_next = retry_reg + 1'b1;
          cap_next   = err_in;
          if (retry_next == RETRY_LIMIT) begin
            state_next = ST_FAULT;
          end else begin
            state_next = ST_RESTORE;
            dwell_next = DWELL_INIT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the state being entered so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cap_reg         <= '0;
      err_stage_reg   <= '0;
      dwell_reg       <= '0;
      retry_reg       <= '0;
      stall_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      clr_reg         <= 1'b0;
      fault_reg       <= 1'b0;
      restore_sel_reg <= '0;
      flush_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      cap_reg         <= cap_next;
      err_stage_reg   <= err_stage_next;
      dwell_reg       <= dwell_next;
      retry_reg       <= retry_next;
      stall_reg       <= (state_next != ST_IDLE);
      busy_reg        <= (state_next != ST_IDLE);
      clr_reg         <= (state_next == ST_CLEAR);
      fault_reg       <= fault_reg | (state_next == ST_FAULT);
      restore_sel_reg <= (state_next == ST_RESTORE) ? cap_next : '0;
      flush_reg       <= (state_next == ST_CLEAR) ? flush_next : '0;
    end
  end

  razor_sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (entry_inc),
    .count (err_count)
  );

`ifdef RAZOR_STAGE_HIST_EN
  logic hist_inc;

  assign hist_inc = (state_next == ST_RESTORE) &&
                    ((state_reg == ST_IDLE) || (state_reg == ST_DRAIN));

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hist
      razor_sat_counter #(.W(8)) u_hist (
        .clk   (clk),
        .reset (reset),
        .inc   (hist_inc & cap_next[gi]),
        .count (stage_hist[gi*8 +: 8])
      );
    end
  endgenerate
`endif

  assign stall       = stall_reg;
  assign busy        = busy_reg;
  assign fault       = fault_reg;
  assign restore_sel = restore_sel_reg;
  assign flush       = flush_reg;
  assign err_stage   = err_stage_reg;
  // Banks are held cleared for as long as reset is asserted.
  assign razor_clr   = clr_reg | reset;

endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Bench for razor_recovery_ctrl: vector table, corner sequences, random vs reference model.
module tb_razor_recovery_ctrl;

  localparam int N = 5;
  localparam int P_IDLE = 0, P_RESTORE = 1, P_CLEAR = 2, P_DRAIN = 3, P_FAULT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] err0, err1;
  logic         stall0, clr0, busy0, fault0, stall1, clr1, busy1, fault1;
  logic [N-1:0] rsel0, flush0, rsel1, flush1;
  logic [2:0]   stage0, stage1;
  logic [15:0]  cnt0;
  logic [1:0]   cnt1;
`ifdef RAZOR_STAGE_HIST_EN
  logic [N*8-1:0] hist0, hist1;
`endif

  razor_recovery_ctrl #(.NUM_STAGES(N), .STALL_CYCLES(1), .MAX_RETRY(3), .CNT_W(16)) d0 (
    .clk(clk), .reset(rst), .err_in(err0), .stall(stall0), .restore_sel(rsel0),
    .flush(flush0), .razor_clr(clr0), .busy(busy0), .fault(fault0),
    .err_stage(stage0), .err_count(cnt0)
`ifdef RAZOR_STAGE_HIST_EN
    , .stage_hist(hist0)
`endif
  );

  razor_recovery_ctrl #(.NUM_STAGES(N), .STALL_CYCLES(2), .MAX_RETRY(2), .CNT_W(2)) d1 (
    .clk(clk), .reset(rst), .err_in(err1), .stall(stall1), .restore_sel(rsel1),
    .flush(flush1), .razor_clr(clr1), .busy(busy1), .fault(fault1),
    .err_stage(stage1), .err_count(cnt1)
`ifdef RAZOR_STAGE_HIST_EN
    , .stage_hist(hist1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst;
    logic [4:0] err;
    logic       stall;
    logic [4:0] rsel;
    logic [4:0] flush;
    logic       clr;
    logic       fault;
    logic [2:0] stage;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic r, input logic [4:0] e, input logic st,
                            input logic [4:0] rs, input logic [4:0] fl, input logic cl,
                            input logic ft, input logic [2:0] sg, input logic [15:0] cn);
    vec_t t;
    t = '{r, e, st, rs, fl, cl, ft, sg, cn};
    tbl.push_back(t);
  endfunction

  // Reference model: phases follow the recovery rules, one step per clock edge.
  int m_ph[2], m_cap[2], m_stage[2], m_left[2], m_tries[2], m_cnt[2];
  int m_hist[2][N];

  function automatic int lowest(input int e);
    for (int i = 0; i < N; i++) if (e[i]) return i;
    return 0;
  endfunction

  function automatic int downstream(input int s);
    int m = 0;
    for (int i = s + 1; i < N; i++) m += (1 << i);
    return m;
  endfunction

  task automatic enter_restore(input int i, input int e, input int sc);
    m_ph[i]   = P_RESTORE;
    m_cap[i]  = e;
    m_left[i] = sc;
    for (int s = 0; s < N; s++) if (e[s] && m_hist[i][s] < 255) m_hist[i][s]++;
  endtask

  task automatic model_step(input int i, input bit r, input int e, input int c);
    int sc, mr, cmax;
    sc   = (i == 0) ? 1 : 2;
    mr   = (i == 0) ? 3 : 2;
    cmax = (i == 0) ? 65535 : 3;
    if (r) begin
      m_ph[i] = P_IDLE; m_cap[i] = 0; m_stage[i] = 0; m_left[i] = 0;
      m_tries[i] = 0; m_cnt[i] = 0;
      for (int s = 0; s < N; s++) m_hist[i][s] = 0;
    end else begin
      case (m_ph[i])
        P_IDLE: if (e != 0) begin
          enter_restore(i, e, sc);
          m_stage[i] = lowest(e);
          m_tries[i] = 0;
          if (m_cnt[i] < cmax) m_cnt[i]++;
          $display("rand d%0d cyc %0d recovery err=%b count=%0d", i, c, e[4:0], m_cnt[i]);
        end
        P_RESTORE: begin
          m_cap[i] = m_cap[i] | e;
          if (e != 0 && lowest(e) < m_stage[i]) m_stage[i] = lowest(e);
          m_left[i]--;
          if (m_left[i] == 0) m_ph[i] = P_CLEAR;
        end
        P_CLEAR: m_ph[i] = P_DRAIN;
        P_DRAIN: begin
          if (e == 0) m_ph[i] = P_IDLE;
          else begin
            m_tries[i]++;
            m_cap[i] = e;
            if (m_tries[i] >= mr) begin
              m_ph[i] = P_FAULT;
              $display("rand d%0d cyc %0d fault entered", i, c);
            end else enter_restore(i, e, sc);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_check(input int i, input bit r);
    logic a_stall, a_busy, a_clr, a_fault;
    logic [4:0] a_rsel, a_flush;
    logic [2:0] a_stage;
    int a_cnt;
    if (i == 0) begin
      a_stall = stall0; a_busy = busy0; a_clr = clr0; a_fault = fault0;
      a_rsel = rsel0; a_flush = flush0; a_stage = stage0; a_cnt = int'(cnt0);
    end else begin
      a_stall = stall1; a_busy = busy1; a_clr = clr1; a_fault = fault1;
      a_rsel = rsel1; a_flush = flush1; a_stage = stage1; a_cnt = int'(cnt1);
    end
    chk($sformatf("rand d%0d stall", i), 32'(a_stall), 32'(m_ph[i] != P_IDLE));
    chk($sformatf("rand d%0d busy", i), 32'(a_busy), 32'(m_ph[i] != P_IDLE));
    chk($sformatf("rand d%0d restore_sel", i), 32'(a_rsel), (m_ph[i] == P_RESTORE) ? m_cap[i] : 0);
    chk($sformatf("rand d%0d flush", i), 32'(a_flush), (m_ph[i] == P_CLEAR) ? downstream(m_stage[i]) : 0);
    chk($sformatf("rand d%0d razor_clr", i), 32'(a_clr), 32'((m_ph[i] == P_CLEAR) || r));
    chk($sformatf("rand d%0d fault", i), 32'(a_fault), 32'(m_ph[i] == P_FAULT));
    chk($sformatf("rand d%0d err_stage", i), 32'(a_stage), m_stage[i]);
    chk($sformatf("rand d%0d err_count", i), a_cnt, m_cnt[i]);
`ifdef RAZOR_STAGE_HIST_EN
    begin
      logic [N*8-1:0] h;
      h = (i == 0) ? hist0 : hist1;
      for (int s = 0; s < N; s++)
        chk($sformatf("rand d%0d stage_hist[%0d]", i, s), 32'(h[s*8 +: 8]), m_hist[i][s]);
    end
`endif
  endtask

  task automatic d1_step(input logic [4:0] e, input logic st, input logic [4:0] rs,
                         input logic [4:0] fl, input logic cl, input logic [2:0] sg,
                         input logic [1:0] cn);
    err1 = e;
    tick();
    chk("d1 stall", 32'(stall1), 32'(st));
    chk("d1 busy", 32'(busy1), 32'(st));
    chk("d1 restore_sel", 32'(rsel1), 32'(rs));
    chk("d1 flush", 32'(flush1), 32'(fl));
    chk("d1 razor_clr", 32'(clr1), 32'(cl));
    chk("d1 fault", 32'(fault1), 32'(1'b0));
    chk("d1 err_stage", 32'(stage1), 32'(sg));
    chk("d1 err_count", 32'(cnt1), 32'(cn));
    $display("d1 err=%b stall=%0b rsel=%b flush=%b clr=%0b stage=%0d count=%0d",
             e, stall1, rsel1, flush1, clr1, stage1, cnt1);
  endtask

  int hold0, hold1, stuck0, stuck1, e0, e1;
  bit r;

  initial begin
    rst = 1'b1; err0 = '0; err1 = '0;
    tick(); tick();

    // d0: STALL_CYCLES=1, MAX_RETRY=3
    v(1, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0, 0, 0);
    v(1, 5'b00100, 0, 5'b00000, 5'b00000, 1, 0, 0, 0);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    v(0, 5'b00100, 1, 5'b00100, 5'b00000, 0, 0, 2, 1);
    v(0, 5'b00100, 1, 5'b00000, 5'b11000, 1, 0, 2, 1);
    v(0, 5'b00100, 1, 5'b00000, 5'b00000, 0, 0, 2, 1);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 2, 1);
    v(0, 5'b01010, 1, 5'b01010, 5'b00000, 0, 0, 1, 2);
    v(0, 5'b00000, 1, 5'b00000, 5'b11100, 1, 0, 1, 2);
    v(0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 1, 2);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1, 2);
    v(0, 5'b10000, 1, 5'b10000, 5'b00000, 0, 0, 4, 3);
    v(0, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 4, 3);
    v(0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 4, 3);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 4, 3);
    for (int k = 0; k < 3; k++) begin
      v(0, 5'b00001, 1, 5'b00001, 5'b00000, 0, 0, 0, 4);
      v(0, 5'b00001, 1, 5'b00000, 5'b11110, 1, 0, 0, 4);
      v(0, 5'b00001, 1, 5'b00000, 5'b00000, 0, 0, 0, 4);
    end
    v(0, 5'b00001, 1, 5'b00000, 5'b00000, 0, 1, 0, 4);
    v(0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 0, 4);
    v(1, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0, 0, 0);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    v(0, 5'b01000, 1, 5'b01000, 5'b00000, 0, 0, 3, 1);
    v(1, 5'b01000, 0, 5'b00000, 5'b00000, 1, 0, 0, 0);
    v(0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      err0 = tbl[k].err;
      tick();
      chk($sformatf("vec%0d stall", k), 32'(stall0), 32'(tbl[k].stall));
      chk($sformatf("vec%0d busy", k), 32'(busy0), 32'(tbl[k].stall));
      chk($sformatf("vec%0d restore_sel", k), 32'(rsel0), 32'(tbl[k].rsel));
      chk($sformatf("vec%0d flush", k), 32'(flush0), 32'(tbl[k].flush));
      chk($sformatf("vec%0d razor_clr", k), 32'(clr0), 32'(tbl[k].clr));
      chk($sformatf("vec%0d fault", k), 32'(fault0), 32'(tbl[k].fault));
      chk($sformatf("vec%0d err_stage", k), 32'(stage0), 32'(tbl[k].stage));
      chk($sformatf("vec%0d err_count", k), 32'(cnt0), 32'(tbl[k].cnt));
      $display("vec %0d rst=%0b err=%b stall=%0b rsel=%b flush=%b clr=%0b fault=%0b stage=%0d count=%0d",
               k, rst, err0, stall0, rsel0, flush0, clr0, fault0, stage0, cnt0);
    end

    // d1: STALL_CYCLES=2, CNT_W=2 -- two-cycle restore, late lower-index error, saturation
    d1_step(5'b01010, 1, 5'b01010, 5'b00000, 0, 1, 1);
    d1_step(5'b00000, 1, 5'b01010, 5'b00000, 0, 1, 1);
    d1_step(5'b00000, 1, 5'b00000, 5'b11100, 1, 1, 1);
    d1_step(5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 1);
    d1_step(5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 1);
    d1_step(5'b00100, 1, 5'b00100, 5'b00000, 0, 2, 2);
    d1_step(5'b00001, 1, 5'b00101, 5'b00000, 0, 0, 2);
    d1_step(5'b00000, 1, 5'b00000, 5'b11110, 1, 0, 2);
    d1_step(5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 2);
    d1_step(5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 2);
    for (int k = 0; k < 3; k++) begin
      d1_step(5'b10000, 1, 5'b10000, 5'b00000, 0, 4, 3);
      d1_step(5'b00000, 1, 5'b10000, 5'b00000, 0, 4, 3);
      d1_step(5'b00000, 1, 5'b00000, 5'b00000, 1, 4, 3);
      d1_step(5'b00000, 1, 5'b00000, 5'b00000, 0, 4, 3);
      d1_step(5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 3);
    end

    // d0: five separate errors on the last stage
    for (int k = 0; k < 5; k++) begin
      err0 = 5'b10000;
      tick();
      err0 = 5'b00000;
      tick(); tick(); tick();
      chk($sformatf("d0 stage4 pulse%0d err_count", k), 32'(cnt0), k + 1);
      chk($sformatf("d0 stage4 pulse%0d busy", k), 32'(busy0), 0);
      $display("d0 stage4 pulse %0d count=%0d", k, cnt0);
    end
`ifdef RAZOR_STAGE_HIST_EN
    chk("d0 stage_hist[39:32]", 32'(hist0[39:32]), 5);
`endif

    // Random traffic on both instances against the reference model.
    rst = 1'b1; err0 = '0; err1 = '0;
    tick();
    model_step(0, 1'b1, 0, 0);
    model_step(1, 1'b1, 0, 0);
    hold0 = 0; hold1 = 0; stuck0 = 0; stuck1 = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 249) == 0);
      if (hold0 == 0 && $urandom_range(0, 99) == 0) begin
        hold0 = $urandom_range(5, 40); stuck0 = $urandom_range(1, 31);
      end
      if (hold1 == 0 && $urandom_range(0, 99) == 0) begin
        hold1 = $urandom_range(5, 40); stuck1 = $urandom_range(1, 31);
      end
      if (hold0 > 0) begin e0 = stuck0; hold0--; end
      else e0 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 0;
      if (hold1 > 0) begin e1 = stuck1; hold1--; end
      else e1 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 0;
      if (r) $display("rand cyc %0d reset", c);
      rst = r;
      err0 = 5'(e0);
      err1 = 5'(e1);
      tick();
      model_step(0, r, e0, c);
      model_step(1, r, e1, c);
      model_check(0, r);
      model_check(1, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
